// File: rtl/inst_cache_nway.sv
// rtl/inst_cache_nway.sv - parametrised N-way read-only instruction cache with blocking misses
module inst_cache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    input  logic        s_uncached,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic        s_rvalid,
    input  logic        flush,
    input  logic        inv,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESP, INV} state_t;
    state_t state, nxt;

    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [31:0]       data_mem [WAYS][SETS*LINE_WORDS];
    logic [TAG_W-1:0]  tag_rd   [WAYS];
    logic [31:0]       data_rd  [WAYS];
    logic [SETS-1:0]   valid    [WAYS];
    logic [WAY_W-1:0]  rr       [SETS];

    logic [31:0]       addr_q, cap_q;
    logic              unc_q, cancel_q, inv_pend_q;
    logic [WAY_W-1:0]  victim_q, victim, hit_way, rr_next;
    logic [WORD_W-1:0] beat_q;
    logic              hit, found_free, start_miss, clear_all, accept, beat;

    logic [IDX_W-1:0]  req_idx, s_idx;
    logic [WORD_W-1:0] req_word, s_word;
    logic [TAG_W-1:0]  req_tag;

    assign req_idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_word = addr_q[OFF_W-1:2];
    assign req_tag  = addr_q[31:32-TAG_W];
    assign s_idx    = s_araddr[OFF_W+IDX_W-1:OFF_W];
    assign s_word   = s_araddr[OFF_W-1:2];
    assign accept   = s_arvalid && s_arready;
    assign beat     = (state == REFILL) && m_rvalid;
    assign m_rready = 1'b1;
    assign rr_next  = (rr[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[req_idx] + 1'b1;

    // Victim prefers the lowest invalid way; only full sets fall back to round-robin.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim     = rr[req_idx];
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][req_idx] && tag_rd[w] == req_tag) begin
                hit     = !unc_q;
                hit_way = WAY_W'(w);
            end
            if (!valid[w][req_idx] && !found_free) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt        = state;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        s_rdata    = '0;
        m_arvalid  = 1'b0;
        start_miss = 1'b0;
        case (state)
            IDLE: begin
                s_arready = !flush && !inv;
                if (inv)                         nxt = INV;
                else if (s_arvalid && s_arready) nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    s_rvalid  = !flush;
                    s_rdata   = data_rd[hit_way];
                    s_arready = !flush && !inv;
                    if (inv)                         nxt = INV;
                    else if (s_arvalid && s_arready) nxt = LOOKUP;
                    else                             nxt = IDLE;
                end else if (flush) begin
                    nxt = inv ? INV : IDLE;
                end else begin
                    nxt        = MISS_AR;
                    start_miss = 1'b1;
                end
            end
            MISS_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) nxt = REFILL;
            end
            REFILL: if (m_rvalid && m_rlast) nxt = RESP;
            RESP: begin
                s_rvalid = !cancel_q;
                s_rdata  = cap_q;
                nxt      = (inv_pend_q || inv) ? INV : IDLE;
            end
            INV:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
        clear_all = (nxt == INV) && (state != INV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            unc_q      <= 1'b0;
            victim_q   <= '0;
            cancel_q   <= 1'b0;
            inv_pend_q <= 1'b0;
            beat_q     <= '0;
            cap_q      <= '0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            if (accept) begin
                addr_q <= s_araddr;
                unc_q  <= s_uncached;
            end
            if (start_miss) begin
                victim_q   <= victim;
                cancel_q   <= 1'b0;
                inv_pend_q <= inv;
                beat_q     <= '0;
                m_araddr   <= unc_q ? addr_q : {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                m_arlen    <= unc_q ? 8'd0 : 8'(LINE_WORDS - 1);
            end
            if ((state == MISS_AR || state == REFILL) && flush) cancel_q <= 1'b1;
            if ((state == MISS_AR || state == REFILL || state == RESP) && inv) inv_pend_q <= 1'b1;
            if (beat) begin
                beat_q <= beat_q + 1'b1;
                if (unc_q ? (beat_q == '0) : (beat_q == req_word)) cap_q <= m_rdata;
                if (m_rlast && !unc_q) begin
                    valid[victim_q][req_idx] <= 1'b1;
                    rr[req_idx]              <= rr_next;
                end
            end
            // A pending invalidate also wipes the line that was just refilled.
            if (clear_all) begin
                for (int w = 0; w < WAYS; w++) valid[w] <= '0;
                for (int s = 0; s < SETS; s++) rr[s] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat && !unc_q) begin
            data_mem[victim_q][{req_idx, beat_q}] <= m_rdata;
            if (m_rlast) tag_mem[victim_q][req_idx] <= req_tag;
        end
        if (accept) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_rd[w]  <= tag_mem[w][s_idx];
                data_rd[w] <= data_mem[w][{s_idx, s_word}];
            end
        end
    end
endmodule

// File: doc/inst_cache_nway.md
Name: inst_cache_nway

Overview:
- Parametrised set-associative, read-only instruction cache with blocking misses.
- Sits between the fetch stage (slave side) and the AXI read channel of the bus bridge (master side).
- Generalises the 2-way/128-set/8-word cache to WAYS, SETS and LINE_WORDS.
- Adds slave backpressure, per-set round-robin replacement, per-request uncached access, whole-cache invalidate, and flush that cancels in-flight responses without corrupting the array.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 128, sets per way; power of two, 2..256.
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16.
- Derived (localparams):
  - OFF_W = log2(LINE_WORDS)+2
  - IDX_W = log2(SETS)
  - TAG_W = 32-IDX_W-OFF_W

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_araddr  in  32  fetch address; word aligned.
- s_arvalid  in  1  fetch request.
- s_uncached  in  1  request bypasses cache; sampled with s_araddr.
- s_arready  out  1  request accepted when s_arvalid&s_arready.
- s_rdata  out  32  instruction word.
- s_rvalid  out  1  one-cycle pulse per returned word.
- flush  in  1  cancel outstanding request; its response is suppressed.
- inv  in  1  invalidate all lines.
- m_araddr  out  32  AXI read address.
- m_arlen  out  8  LINE_WORDS-1 for cached requests, 0 for uncached.
- m_arvalid  out  1  held until m_arready.
- m_arready  in  1
- m_rdata  in  32
- m_rvalid  in  1
- m_rlast  in  1
- m_rready  out  1  tied 1.

Behaviour:
- Reset values:
  - all valid bits 0; all round-robin pointers 0; state IDLE.
  - s_rvalid=0, s_rdata=0, m_arvalid=0, m_araddr=0, m_arlen=0, s_arready=1.
  - Reset mid-refill abandons the burst immediately; later beats are ignored.
- Address split: tag=[31:32-TAG_W], index=[OFF_W+IDX_W-1:OFF_W], word=[OFF_W-1:2].
- Storage:
  - tag/data arrays are synchronous-read register arrays, read at acceptance; no reset on array contents.
  - valid bits are flops, cleared by rst or inv.
- States: IDLE, LOOKUP, MISS_AR, REFILL, RESP, INV.
- s_arready=1 only in IDLE, and in LOOKUP on a hit (back-to-back hits at 1/cycle); 0 otherwise.
- IDLE: accept -> LOOKUP; latch address and uncached flag.
- LOOKUP (cycle after accept):
  - Cached hit (exactly one way valid and tag-equal): s_rvalid=1 with the hit way's word this cycle (1-cycle latency); no replacement-state change. Next state is LOOKUP if a new request is accepted, else IDLE.
  - Cached miss: victim = lowest-index invalid way, else rr[index]; rr[index] increments mod WAYS on every miss fill. -> MISS_AR.
  - Uncached: never compares or fills -> MISS_AR.
- MISS_AR:
  - m_arvalid=1.
  - m_araddr = line-aligned address (cached) or exact address (uncached).
  - m_arlen as above.
  - On m_arready -> REFILL.
- REFILL:
  - Each m_rvalid beat writes beat counter k into victim word k; counter wraps at LINE_WORDS.
  - Beat whose k equals the requested word is captured.
  - On m_rvalid&m_rlast: set victim tag and valid -> RESP.
  - Uncached: single beat captured, no array write.
- RESP: s_rvalid=1, s_rdata=captured word, one cycle -> IDLE (arrays readable next cycle).
- flush:
  - In LOOKUP: suppresses s_rvalid that cycle and blocks acceptance that cycle.
  - In MISS_AR/REFILL: sets a cancel flag; the burst completes and the line is filled, but RESP emits no s_rvalid.
  - flush and a new s_arvalid in the same IDLE cycle: request is dropped (s_arready=0 while flush=1).
- inv:
  - In IDLE/LOOKUP: all valid bits and rr pointers cleared next edge; state INV for one cycle (s_arready=0); a LOOKUP hit that same cycle still returns.
  - During a miss: pending, applied after RESP, and the refilled line is invalidated too.
- Fill logic requires m_rlast on beat LINE_WORDS-1; a mismatch is a bus error outside scope.

Test Plan:
- Cold miss: reset, fetch 0x1FC0_0004 cached, memory returns words i*0x11 -> m_araddr=0x1FC0_0000, m_arlen=7; s_rvalid with 0x11 one cycle after RESP entry. Refetch 0x1FC0_0008 -> hit, s_rvalid=0x22 one cycle after acceptance, no AR.
- Back-to-back hits 0x..00..0x..1C on a filled line -> 8 s_rvalid pulses on 8 consecutive cycles, s_arready held 1.
- Replacement, WAYS=2: fill addresses A, A+4K, A+8K (same index) -> third miss evicts way0. Refetch A -> miss; A+8K -> hit.
- Uncached 0xBFC0_0010 -> m_arlen=0, m_araddr=0xBFC0_0010, returns bus data. Cached refetch of same index -> miss (no fill occurred).
- flush asserted during REFILL beat 3 -> burst completes, no s_rvalid. Refetch same address -> hit.
- inv after two fills -> both refetches miss. rst asserted mid-REFILL -> m_arvalid=0 and s_rvalid=0 immediately; next fetch misses.
